// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: windowed spike-rate counter with valid/ready output and inter-spike interval measurement.
// Define SPIKE_RATE_SEG7_EN to add a registered 7-segment readout (gfedcba) of the rate's top nibble.
module spike_rate_decoder #(
    parameter int WINDOW_LEN = 16,
    parameter int CNT_W = 5,
    parameter int ISI_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spike,
    input  logic             enable,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [CNT_W-1:0] rate,
    output logic [ISI_W-1:0] last_isi,
`ifdef SPIKE_RATE_SEG7_EN
    output logic [6:0]       seg,
`endif
    output logic             overrun
);
    localparam int WIN_W = $clog2(WINDOW_LEN);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] COUNT = 1'b1;
    logic [0:0] state;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] spk_cnt, spk_next;
    logic [ISI_W-1:0] isi_cnt, isi_next;
    logic last_cycle, load;
    always_comb begin
        spk_next = (&spk_cnt || !spike) ? spk_cnt : spk_cnt + CNT_W'(1);
        isi_next = &isi_cnt ? isi_cnt : isi_cnt + ISI_W'(1);
        last_cycle = state == COUNT && win_cnt == WIN_W'(WINDOW_LEN - 1);
        load = enable && last_cycle;
    end
    // The IDLE->COUNT cycle is window cycle 0, so counting logic is shared with COUNT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            win_cnt <= '0;
            spk_cnt <= '0;
            isi_cnt <= '0;
            out_valid <= 1'b0;
            rate <= '0;
            last_isi <= '0;
            overrun <= 1'b0;
        end else begin
            state <= enable ? COUNT : IDLE;
            win_cnt <= (!enable || last_cycle) ? '0 : win_cnt + WIN_W'(1);
            spk_cnt <= (!enable || last_cycle) ? '0 : spk_next;
            if (load) rate <= spk_next;
            out_valid <= load || (out_valid && !out_ready);
            if (load && out_valid && !out_ready) overrun <= 1'b1;
            if (spike) last_isi <= isi_next;
            isi_cnt <= spike ? '0 : isi_next;
        end
    end
`ifdef SPIKE_RATE_SEG7_EN
    localparam int SEG_SH = CNT_W > 4 ? CNT_W - 4 : 0;
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
        7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71
    };
    logic [3:0] seg_nib;
    always_comb seg_nib = 4'(spk_next >> SEG_SH);
    always_ff @(posedge clk) begin
        if (reset) seg <= 7'h3f;
        else if (load) seg <= SEG_LUT[seg_nib];
    end
`endif
endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb_spike_rate_decoder: randomized and directed stimulus with a queue scoreboard and a window/ISI reference model.
module tb_spike_rate_decoder;
    localparam int WL = 16;
    localparam int CW = 5;
    localparam int IW = 8;
    localparam int RMAX = (1 << CW) - 1;
    localparam int IMAX = (1 << IW) - 1;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic spike = 1'b0, enable = 1'b0, out_ready = 1'b0;
    logic out_valid, overrun;
    logic [CW-1:0] rate;
    logic [IW-1:0] last_isi;
    logic spike2 = 1'b0, enable2 = 1'b0, ready2 = 1'b1;
    logic out_valid2, overrun2;
    logic [2:0] rate2;
    logic [3:0] last_isi2;
`ifdef SPIKE_RATE_SEG7_EN
    logic [6:0] seg, seg2;
    localparam logic [6:0] SEG_TAB [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100, 7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };
    logic [6:0] exp_seg = 7'b0111111;
`endif
    int tests = 0, fails = 0;
    int exp_q[$];
    bit exp_ovr = 1'b0;
    int exp_isi = 0, cyc = 0, prev_spk = -1, win_pos = 0, win_sum = 0;
    bit seen;

    always #5 clk = ~clk;

    spike_rate_decoder #(.WINDOW_LEN(WL), .CNT_W(CW), .ISI_W(IW)) dut (
        .clk(clk), .reset(reset), .spike(spike), .enable(enable), .out_ready(out_ready),
        .out_valid(out_valid), .rate(rate), .last_isi(last_isi),
`ifdef SPIKE_RATE_SEG7_EN
        .seg(seg),
`endif
        .overrun(overrun)
    );

    spike_rate_decoder #(.WINDOW_LEN(16), .CNT_W(3), .ISI_W(4)) dut2 (
        .clk(clk), .reset(reset), .spike(spike2), .enable(enable2), .out_ready(ready2),
        .out_valid(out_valid2), .rate(rate2), .last_isi(last_isi2),
`ifdef SPIKE_RATE_SEG7_EN
        .seg(seg2),
`endif
        .overrun(overrun2)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", n, act, req);
        end
    endtask

    // Reference model: windows are counted by position since enable rose; ISI from spike timestamps.
    task automatic commit();
        int v;
        if (spike) begin
            v = cyc - prev_spk;
            exp_isi = v > IMAX ? IMAX : v;
            prev_spk = cyc;
        end
        cyc++;
        if (!enable) begin
            win_pos = 0;
            win_sum = 0;
        end else begin
            win_sum += int'(spike);
            if (win_pos == WL - 1) begin
                v = win_sum > RMAX ? RMAX : win_sum;
                if (exp_q.size() != 0) begin
                    exp_ovr = 1'b1;
                    exp_q.delete();
                end
                exp_q.push_back(v);
`ifdef SPIKE_RATE_SEG7_EN
                exp_seg = SEG_TAB[v >> (CW - 4)];
`endif
                win_pos = 0;
                win_sum = 0;
            end else win_pos++;
        end
    endtask

    task automatic step(input bit s, input bit e, input bit r);
        spike = s;
        enable = e;
        out_ready = r;
        @(posedge clk);
        #1;
        commit();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        exp_ovr = 1'b0;
        exp_isi = 0;
        cyc = 0;
        prev_spk = -1;
        win_pos = 0;
        win_sum = 0;
`ifdef SPIKE_RATE_SEG7_EN
        exp_seg = 7'b0111111;
`endif
    endtask

    // Monitor: sampled mid-cycle, so out_valid && out_ready here is the handshake of the coming edge.
    always @(negedge clk) begin
        if (!reset) begin
            chk("valid", out_valid, exp_q.size() != 0);
            chk("overrun", overrun, exp_ovr);
            chk("last_isi", last_isi, exp_isi);
`ifdef SPIKE_RATE_SEG7_EN
            chk("seg", seg, exp_seg);
`endif
            if (out_valid && exp_q.size() != 0) begin
                chk("rate", rate, exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        do_reset(2);
        chk("rst_rate", rate, 0);
        chk("rst_valid", out_valid, 0);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 48; i++) step(i % 4 == 0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0);
        chk("ovr_set", overrun, 1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1);
        chk("ovr_sticky", overrun, 1);
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(i % 2 == 0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(i % 3 == 0, 1'b1, 1'b1);
        spike2 = 1'b1;
        enable2 = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0, 1'b1);
            if (out_valid2) begin
                seen = 1'b1;
                chk("rate2_sat", rate2, 7);
            end
        end
        chk("rate2_seen", seen, 1);
        spike2 = 1'b0;
        enable2 = 1'b0;
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b1);
        spike2 = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        spike2 = 1'b0;
        chk("isi2_sat", last_isi2, 15);
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 1) == 1, $urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0);
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 3) == 0, $urandom_range(0, 31) != 0, $urandom_range(0, 7) == 0);
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0);
        chk("pre_rst_valid", out_valid, 1);
        do_reset(1);
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_rate", rate, 0);
        chk("post_rst_isi", last_isi, 0);
        chk("post_rst_ovr", overrun, 0);
`ifdef SPIKE_RATE_SEG7_EN
        chk("post_rst_seg", seg, 7'b0111111);
`endif
        for (int i = 0; i < 17; i++) step(1'b1, 1'b1, 1'b1);
        chk("win16_rate", rate, 16);
`ifdef SPIKE_RATE_SEG7_EN
        chk("seg8", seg, 7'b1111111);
`endif
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
